// File: rtl/ofdm_pkg.sv
// Shared types and default constants for the OFDM transmit chain.
package ofdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT_CP,
    EMIT_SYM
  } cp_state_t;

  localparam int FFT_DATA_W  = 16;
  localparam int FFT_N_LOG2  = 6;
  localparam int OFDM_CP_LEN = 16;

endpackage

// File: rtl/fft_cp_inserter_if.sv
// Complex-sample stream with sop/eop framing and valid/ready handshake.
interface fft_cp_inserter_if #(
  parameter int DATA_W = 16
);
  logic              valid;
  logic              ready;
  logic              sop;
  logic              eop;
  logic [1:0]        error;
  logic [DATA_W-1:0] re;
  logic [DATA_W-1:0] im;

  modport master (output valid, sop, eop, error, re, im, input ready);
  modport slave  (input valid, sop, eop, error, re, im, output ready);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module sdp_ram #(
  parameter int DEPTH_LOG2 = 6,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // read data holds while rd_en is low so a stalled output can be reloaded later
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_cp_inserter.sv
// Buffers one IFFT frame and re-emits it as an OFDM symbol with cyclic prefix.
module fft_cp_inserter
  import ofdm_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int CP_LEN = OFDM_CP_LEN
) (
  input  logic                clk,
  input  logic                reset_n,
  fft_cp_inserter_if.slave    in_s,
  fft_cp_inserter_if.master   out_m,
  output logic                frame_err,
  output logic                busy
);

  localparam logic [N_LOG2-1:0] LAST     = '1;
  localparam logic [N_LOG2-1:0] CP_START = N_LOG2'((2**N_LOG2) - CP_LEN);

  cp_state_t           state, state_nx;
  logic [N_LOG2-1:0]   wr_cnt, wr_cnt_nx, rd_cnt, rd_cnt_nx, wr_addr;
  logic                rd_done, rd_done_nx, drop, wr_en;
  logic                accept, issue, load_out, out_xfer;
  logic                rd_vld, rd_sop, rd_eop;
  logic [2*DATA_W-1:0] rd_data;

  assign in_s.ready  = (state == IDLE) || (state == FILL);
  assign busy        = (state != IDLE);
  assign out_m.error = '0;
  assign accept      = in_s.valid & in_s.ready;
  assign out_xfer    = out_m.valid & out_m.ready;
  assign load_out    = rd_vld & (!out_m.valid | out_m.ready);
  // prefetch: issue a read whenever the RAM output stage is empty or being drained
  assign issue       = ((state == EMIT_CP) || (state == EMIT_SYM && !rd_done)) &&
                       (!rd_vld || load_out);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      wr_cnt    <= wr_cnt_nx;
      rd_cnt    <= rd_cnt_nx;
      rd_done   <= rd_done_nx;
      frame_err <= drop;
    end
  end

  always_comb begin
    state_nx   = state;
    wr_cnt_nx  = wr_cnt;
    rd_cnt_nx  = rd_cnt;
    rd_done_nx = rd_done;
    drop       = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = wr_cnt;
    case (state)
      IDLE: begin
        if (accept && in_s.sop) begin
          if (in_s.error != 2'b00 || in_s.eop) begin
            drop = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            wr_cnt_nx = N_LOG2'(1);
            state_nx  = FILL;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (in_s.error != 2'b00 || (in_s.sop && in_s.eop)) begin
            drop      = 1'b1;
            state_nx  = IDLE;
            wr_cnt_nx = '0;
          end else if (in_s.sop) begin
            drop      = 1'b1;
            wr_en     = 1'b1;
            wr_addr   = '0;
            wr_cnt_nx = N_LOG2'(1);
          end else if (in_s.eop && wr_cnt == LAST) begin
            wr_en     = 1'b1;
            state_nx  = EMIT_CP;
            rd_cnt_nx = CP_START;
          end else if (in_s.eop || wr_cnt == LAST) begin
            drop      = 1'b1;
            state_nx  = IDLE;
            wr_cnt_nx = '0;
          end else begin
            wr_en     = 1'b1;
            wr_cnt_nx = wr_cnt + 1'b1;
          end
        end
      end
      EMIT_CP: begin
        if (issue) begin
          rd_cnt_nx = rd_cnt + 1'b1;
          if (rd_cnt == LAST) state_nx = EMIT_SYM;
        end
      end
      EMIT_SYM: begin
        if (issue) begin
          rd_cnt_nx = rd_cnt + 1'b1;
          if (rd_cnt == LAST) rd_done_nx = 1'b1;
        end
        // input stays closed until the final sample has actually left
        if (out_xfer && out_m.eop) begin
          state_nx   = IDLE;
          wr_cnt_nx  = '0;
          rd_done_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  sdp_ram #(
    .DEPTH_LOG2 (N_LOG2),
    .WIDTH      (2*DATA_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({in_s.re, in_s.im}),
    .rd_en   (issue),
    .rd_addr (rd_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_vld <= 1'b0;
      rd_sop <= 1'b0;
      rd_eop <= 1'b0;
    end else if (issue) begin
      rd_vld <= 1'b1;
      rd_sop <= (state == EMIT_CP) && (rd_cnt == CP_START);
      rd_eop <= (state == EMIT_SYM) && (rd_cnt == LAST);
    end else if (load_out) begin
      rd_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_m.valid <= 1'b0;
      out_m.sop   <= 1'b0;
      out_m.eop   <= 1'b0;
      out_m.re    <= '0;
      out_m.im    <= '0;
    end else if (load_out) begin
      out_m.valid <= 1'b1;
      out_m.sop   <= rd_sop;
      out_m.eop   <= rd_eop;
      {out_m.re, out_m.im} <= rd_data;
    end else if (out_m.ready) begin
      out_m.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_cp_inserter.sv
// Directed bench for fft_cp_inserter: clean, stalled, malformed and reset-interrupted frames.
module tb_fft_cp_inserter;
  import ofdm_pkg::*;

  localparam int N   = 64;
  localparam int CP  = 16;
  localparam int DW  = 16;
  localparam int SYM = N + CP;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_err, busy;

  fft_cp_inserter_if #(.DATA_W(DW)) in_if ();
  fft_cp_inserter_if #(.DATA_W(DW)) out_if ();

  fft_cp_inserter #(
    .DATA_W (DW),
    .N_LOG2 (6),
    .CP_LEN (CP)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_s      (in_if.slave),
    .out_m     (out_if.master),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  int          err_pulses = 0;
  int          first_valid_cyc = 0;
  bit          seen_valid = 1'b0;
  bit          prev_stall = 1'b0;
  logic [33:0] held;
  logic [33:0] q [$];
  int          eop_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // output monitor: collects transferred beats, checks stall hold and closed input
  initial forever begin
    logic [33:0] cur;
    @(negedge clk);
    cur = {out_if.sop, out_if.eop, out_if.re, out_if.im};
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'(cur), 64'(held));
      if (out_if.valid) begin
        chk("in_ready_emit", 64'(in_if.ready), 64'd0);
        if (!seen_valid) begin
          seen_valid      = 1'b1;
          first_valid_cyc = cyc;
        end
        if (out_if.ready) q.push_back(cur);
      end
      prev_stall = out_if.valid && !out_if.ready;
      held       = cur;
      if (frame_err) err_pulses++;
    end
  end

  task automatic beat(input bit sop, input bit eop, input logic [1:0] err,
                      input logic [15:0] re, input logic [15:0] im);
    in_if.valid = 1'b1;
    in_if.sop   = sop;
    in_if.eop   = eop;
    in_if.error = err;
    in_if.re    = re;
    in_if.im    = im;
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.sop   = 1'b0;
    in_if.eop   = 1'b0;
    in_if.error = 2'b00;
  endtask

  task automatic send_frame(input int base, input int nbeats, input int eop_at, input int err_at);
    for (int k = 0; k < nbeats; k++) begin
      beat(k == 0, k == eop_at, (k == err_at) ? 2'b01 : 2'b00,
           16'(base + k), 16'(-(base + k)));
      if (k == eop_at) eop_cyc = cyc;
    end
  endtask

  task automatic clear_mon();
    q.delete();
    seen_valid = 1'b0;
    err_pulses = 0;
  endtask

  task automatic expect_symbol(input string tag, input int base, input bit tog);
    int budget = 0;
    int lim;
    int addr;
    int v;
    logic [33:0] exp;
    while (q.size() < SYM && budget < 600) begin
      @(posedge clk);
      #1;
      if (tog) out_if.ready = ~out_if.ready;
      budget++;
    end
    out_if.ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(q.size()), 64'(SYM));
    lim = (q.size() < SYM) ? q.size() : SYM;
    for (int j = 0; j < lim; j++) begin
      addr = (j < CP) ? (N - CP + j) : (j - CP);
      v    = base + addr;
      exp  = {(j == 0), (j == SYM - 1), 16'(v), 16'(-v)};
      chk(tag, 64'(q[j]), 64'(exp));
    end
  endtask

  initial begin
    int budget;
    in_if.valid  = 1'b0;
    in_if.sop    = 1'b0;
    in_if.eop    = 1'b0;
    in_if.error  = 2'b00;
    in_if.re     = '0;
    in_if.im     = '0;
    out_if.ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_if.ready),  64'd1);
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk("rst_out_sop",   64'(out_if.sop),   64'd0);
    chk("rst_out_eop",   64'(out_if.eop),   64'd0);
    chk("rst_out_data",  64'({out_if.re, out_if.im}), 64'd0);
    chk("rst_frame_err", 64'(frame_err),    64'd0);
    chk("rst_busy",      64'(busy),         64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // clean frame, full throughput
    clear_mon();
    send_frame(0, N, N - 1, -1);
    expect_symbol("clean", 0, 1'b0);
    chk("first_valid_lat", 64'(first_valid_cyc - eop_cyc), 64'd2);
    chk("clean_no_err", 64'(err_pulses), 64'd0);
    chk("clean_idle", 64'(busy), 64'd0);

    // same frame, out_ready toggling every cycle
    clear_mon();
    send_frame(0, N, N - 1, -1);
    expect_symbol("stall", 0, 1'b1);

    // early eop at beat 40, then a clean frame
    clear_mon();
    send_frame(0, 41, 40, -1);
    repeat (150) @(posedge clk);
    #1;
    chk("early_eop_err",   64'(err_pulses), 64'd1);
    chk("early_eop_nout",  64'(q.size()),   64'd0);
    chk("early_eop_busy",  64'(busy),       64'd0);
    clear_mon();
    send_frame(200, N, N - 1, -1);
    expect_symbol("after_early", 200, 1'b0);

    // error flag on beat 10
    clear_mon();
    send_frame(100, N, N - 1, 10);
    repeat (150) @(posedge clk);
    #1;
    chk("in_err_pulse",  64'(err_pulses), 64'd1);
    chk("in_err_nvalid", 64'(seen_valid), 64'd0);
    chk("in_err_busy",   64'(busy),       64'd0);

    // sop re-asserted at beat 30: only the restarted frame is emitted
    clear_mon();
    send_frame(300, 30, -1, -1);
    send_frame(400, N, N - 1, -1);
    expect_symbol("resop", 400, 1'b0);
    chk("resop_err", 64'(err_pulses), 64'd1);

    // reset pulse in the middle of the symbol body
    clear_mon();
    send_frame(500, N, N - 1, -1);
    budget = 0;
    while (q.size() < CP + 50 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    chk("rst_mid_reached", 64'(q.size() >= CP + 50), 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid",    64'(out_if.valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_if.ready),  64'd1);
    chk("rst_mid_busy",     64'(busy),         64'd0);
    @(posedge clk);
    #1;
    clear_mon();
    send_frame(600, N, N - 1, -1);
    expect_symbol("after_rst", 600, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
